// File: rtl/gol_pkg.sv
// Shared types, rule defaults and bit helpers for the Game-of-Life engine.
package gol_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    UPDATE,
    WAIT_COMMIT
  } gol_state_t;

  localparam logic [8:0]  RULE_B3   = 9'h008;
  localparam logic [8:0]  RULE_S23  = 9'h00C;
  // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int unsigned i = 0; i < 32; i++) n = n + {5'b0, v[i]};
    return n;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/gol_engine_if.sv
// Control and display-read bus between the UI/renderer side and the engine.
interface gol_engine_if #(
  parameter int LOG_W = 4,
  parameter int LOG_H = 4
);
  logic                   frame_tick;
  logic                   run;
  logic                   step;
  logic                   random_fill;
  logic                   clear;
  logic [31:0]            seed;
  logic [LOG_W-1:0]       rd_x;
  logic [LOG_H-1:0]       rd_y;
  logic                   rd_alive;
  logic                   busy;
  logic [15:0]            gen_count;
  logic [LOG_W+LOG_H:0]   pop_count;

  modport master (
    output frame_tick, run, step, random_fill, clear, seed, rd_x, rd_y,
    input  rd_alive, busy, gen_count, pop_count
  );

  modport slave (
    input  frame_tick, run, step, random_fill, clear, seed, rd_x, rd_y,
    output rd_alive, busy, gen_count, pop_count
  );
endinterface

// File: rtl/gol_row_next.sv
// Next-generation value of one board row from its three-row neighbourhood.
module gol_row_next
  import gol_pkg::*;
#(
  parameter int         LOG_W        = 4,
  parameter logic       WRAP         = 1'b1,
  parameter logic [8:0] RULE_BIRTH   = RULE_B3,
  parameter logic [8:0] RULE_SURVIVE = RULE_S23
) (
  input  logic [(1<<LOG_W)-1:0] above,
  input  logic [(1<<LOG_W)-1:0] mid,
  input  logic [(1<<LOG_W)-1:0] below,
  output logic [(1<<LOG_W)-1:0] next_row,
  output logic [LOG_W:0]        row_pop
);
  localparam int W = 1 << LOG_W;

  logic [W+1:0] pa, pm, pb;
  logic [3:0]   n;

  always_comb begin
    // Pad each row with its off-board column: bit 0 is column -1, bit W+1 is column W.
    pa = {WRAP ? above[0] : 1'b0, above, WRAP ? above[W-1] : 1'b0};
    pm = {WRAP ? mid[0]   : 1'b0, mid,   WRAP ? mid[W-1]   : 1'b0};
    pb = {WRAP ? below[0] : 1'b0, below, WRAP ? below[W-1] : 1'b0};
    n        = '0;
    next_row = '0;
    for (int unsigned x = 0; x < W; x++) begin
      n = 4'(pa[x]) + 4'(pa[x+1]) + 4'(pa[x+2]) +
          4'(pm[x])               + 4'(pm[x+2]) +
          4'(pb[x]) + 4'(pb[x+1]) + 4'(pb[x+2]);
      next_row[x] = pm[x+1] ? RULE_SURVIVE[n] : RULE_BIRTH[n];
    end
    row_pop = (LOG_W+1)'(popcount(32'(next_row)));
  end

endmodule

// File: rtl/gol_engine.sv
// Game-of-Life engine: double-buffered WxH board, one row per clock, commit on frame_tick.
module gol_engine
  import gol_pkg::*;
#(
  parameter int          LOG_W        = 4,
  parameter int          LOG_H        = 4,
  parameter logic        WRAP         = 1'b1,
  parameter logic [8:0]  RULE_BIRTH   = RULE_B3,
  parameter logic [8:0]  RULE_SURVIVE = RULE_S23,
  parameter logic [7:0]  INTERVAL     = 8'd6,
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1
) (
  input logic         clk,
  input logic         reset,
  gol_engine_if.slave bus
);
  localparam int unsigned W  = 1 << LOG_W;
  localparam int unsigned H  = 1 << LOG_H;
  localparam int          PW = LOG_W + LOG_H + 1;

  gol_state_t state, state_next;

  logic [W-1:0]     cur [H];
  logic [W-1:0]     nxt [H];
  logic [LOG_H-1:0] row, row_up, row_dn;
  logic [7:0]       timer;
  logic [31:0]      lfsr;
  logic             fill_rand;
  logic [PW-1:0]    accum;
  logic [PW-1:0]    pop_count;
  logic [15:0]      gen_count;
  logic [W-1:0]     above, below, calc_row, fill_row;
  logic [LOG_W:0]   calc_pop, fill_pop;
  logic             timer_hit, last_row, start_rand;

  assign last_row   = (row == '1);
  assign timer_hit  = bus.run && bus.frame_tick && (timer == INTERVAL - 8'd1);
  assign start_rand = ~bus.clear & bus.random_fill;
  assign row_up     = row - LOG_H'(1);
  assign row_dn     = row + LOG_H'(1);
  assign above      = (!WRAP && row == '0) ? '0 : cur[row_up];
  assign below      = (!WRAP && last_row)  ? '0 : cur[row_dn];
  assign fill_row   = fill_rand ? lfsr[W-1:0] : '0;
  assign fill_pop   = (LOG_W+1)'(popcount(32'(fill_row)));

  gol_row_next #(
    .LOG_W       (LOG_W),
    .WRAP        (WRAP),
    .RULE_BIRTH  (RULE_BIRTH),
    .RULE_SURVIVE(RULE_SURVIVE)
  ) u_row_next (
    .above   (above),
    .mid     (cur[row]),
    .below   (below),
    .next_row(calc_row),
    .row_pop (calc_pop)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.clear || bus.random_fill)        state_next = FILL;
        else if ((bus.step && !bus.run) || timer_hit) state_next = UPDATE;
      end
      FILL:        if (last_row)       state_next = IDLE;
      UPDATE:      if (last_row)       state_next = WAIT_COMMIT;
      WAIT_COMMIT: if (bus.frame_tick) state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 timer <= '0;
    else if (!bus.run)                         timer <= '0;
    else if (state == IDLE && bus.frame_tick)  timer <= timer_hit ? '0 : timer + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < H; i++) begin
        cur[i] <= '0;
        nxt[i] <= '0;
      end
      row       <= '0;
      lfsr      <= SEED_DEFAULT;
      fill_rand <= 1'b0;
      accum     <= '0;
      gen_count <= '0;
      pop_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          row       <= '0;
          accum     <= '0;
          fill_rand <= start_rand;
          if (start_rand) lfsr <= (bus.seed == '0) ? SEED_DEFAULT : bus.seed;
        end
        FILL: begin
          cur[row] <= fill_row;
          row      <= row + LOG_H'(1);
          accum    <= accum + PW'(fill_pop);
          if (fill_rand) lfsr <= lfsr_next(lfsr);
          if (last_row) begin
            pop_count <= accum + PW'(fill_pop);
            gen_count <= '0;
          end
        end
        UPDATE: begin
          nxt[row] <= calc_row;
          row      <= row + LOG_H'(1);
          accum    <= accum + PW'(calc_pop);
        end
        WAIT_COMMIT: begin
          if (bus.frame_tick) begin
            for (int unsigned i = 0; i < H; i++) cur[i] <= nxt[i];
            gen_count <= gen_count + 16'd1;
            pop_count <= accum;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_alive  = cur[bus.rd_y][bus.rd_x];
  assign bus.busy      = (state != IDLE);
  assign bus.gen_count = gen_count;
  assign bus.pop_count = pop_count;

endmodule

// File: tb/tb_gol_engine.sv
// Two engines (torus B3/S23 and dead-border HighLife) fed one control stream, checked against a cell-level model.
module tb_gol_engine;
  localparam int LW = 4;
  localparam int LH = 4;
  localparam int W  = 16;
  localparam int H  = 16;
  localparam int NB = 2;

  logic clk = 1'b0;
  logic reset;
  always #500 clk = ~clk;

  gol_engine_if #(.LOG_W(LW), .LOG_H(LH)) ifa ();
  gol_engine_if #(.LOG_W(LW), .LOG_H(LH)) ifb ();

  gol_engine #(
    .LOG_W(LW), .LOG_H(LH), .WRAP(1'b1), .RULE_BIRTH(9'h008), .RULE_SURVIVE(9'h00C),
    .INTERVAL(8'd3), .SEED_DEFAULT(32'hACE1)
  ) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));

  gol_engine #(
    .LOG_W(LW), .LOG_H(LH), .WRAP(1'b0), .RULE_BIRTH(9'h048), .RULE_SURVIVE(9'h00C),
    .INTERVAL(8'd3), .SEED_DEFAULT(32'hACE1)
  ) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  assign ifb.frame_tick  = ifa.frame_tick;
  assign ifb.run         = ifa.run;
  assign ifb.step        = ifa.step;
  assign ifb.random_fill = ifa.random_fill;
  assign ifb.clear       = ifa.clear;
  assign ifb.seed        = ifa.seed;
  assign ifb.rd_x        = ifa.rd_x;
  assign ifb.rd_y        = ifa.rd_y;

  // Reference model: per-engine board, rules and edge mode.
  logic [W-1:0] mb [NB][H];
  int           mgen;
  logic         m_wrap  [NB] = '{1'b1, 1'b0};
  logic [8:0]   m_birth [NB] = '{9'h008, 9'h048};
  logic [8:0]   m_surv  [NB] = '{9'h00C, 9'h00C};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_fill(input logic [31:0] sd, input logic rnd);
    logic [31:0] s;
    s = (sd == 32'd0) ? 32'hACE1 : sd;
    for (int y = 0; y < H; y++) begin
      for (int b = 0; b < NB; b++) mb[b][y] = rnd ? s[15:0] : 16'h0000;
      if (s % 2 == 1) s = (s >> 1) ^ 32'h8020_0003;
      else            s = s >> 1;
    end
    mgen = 0;
  endtask

  task automatic model_gen();
    logic [W-1:0] nb [NB][H];
    logic [8:0]   rule;
    for (int b = 0; b < NB; b++) begin
      for (int y = 0; y < H; y++) begin
        for (int x = 0; x < W; x++) begin
          int n;
          n = 0;
          for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
              int yy, xx;
              yy = y + dy;
              xx = x + dx;
              if (m_wrap[b]) begin
                yy = (yy + H) % H;
                xx = (xx + W) % W;
              end
              if ((dy != 0 || dx != 0) && yy >= 0 && yy < H && xx >= 0 && xx < W)
                n += int'(mb[b][yy][xx]);
            end
          end
          rule = mb[b][y][x] ? m_surv[b] : m_birth[b];
          nb[b][y][x] = rule[n];
        end
      end
    end
    mb   = nb;
    mgen = (mgen + 1) % 65536;
  endtask

  function automatic logic [255:0] mvec(input int b);
    logic [255:0] v;
    v = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) v[y*W+x] = mb[b][y][x];
    return v;
  endfunction

  function automatic int mpop(input int b);
    int n;
    n = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) n += int'(mb[b][y][x]);
    return n;
  endfunction

  // One rd_alive sample per time unit; a full scan stays inside the high clock phase.
  task automatic read_boards(output logic [255:0] va, output logic [255:0] vb);
    va = '0;
    vb = '0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        ifa.rd_x = 4'(x);
        ifa.rd_y = 4'(y);
        #1;
        va[y*W+x] = ifa.rd_alive;
        vb[y*W+x] = ifb.rd_alive;
      end
    end
  endtask

  task automatic check_boards(input string tag);
    logic [255:0] va, vb;
    read_boards(va, vb);
    chk({tag, "_board_a"}, va, mvec(0));
    chk({tag, "_board_b"}, vb, mvec(1));
  endtask

  task automatic check_state(input string tag);
    check_boards(tag);
    chk({tag, "_pop_a"}, 256'(ifa.pop_count), 256'(mpop(0)));
    chk({tag, "_pop_b"}, 256'(ifb.pop_count), 256'(mpop(1)));
    chk({tag, "_gen_a"}, 256'(ifa.gen_count), 256'(mgen));
    chk({tag, "_gen_b"}, 256'(ifb.gen_count), 256'(mgen));
    chk({tag, "_busy"}, 256'({ifa.busy, ifb.busy}), 256'(0));
  endtask

  task automatic do_fill(input string tag, input logic [31:0] sd, input logic rnd, input logic clr);
    int n;
    ifa.seed        = sd;
    ifa.random_fill = rnd;
    ifa.clear       = clr;
    cyc();
    ifa.random_fill = 1'b0;
    ifa.clear       = 1'b0;
    ifa.seed        = $urandom;
    n = 0;
    while ((ifa.busy || ifb.busy) && n < 100) begin
      n++;
      cyc();
    end
    chk({tag, "_fill_cycles"}, 256'(n), 256'(H));
    if (clr) model_fill(32'd0, 1'b0);
    else     model_fill(sd, rnd);
    check_state(tag);
  endtask

  // Step with tearing checks, dropped commands while busy, and a tick on the last row that must not commit.
  task automatic do_step(input string tag);
    ifa.step = 1'b1;
    cyc();
    ifa.step = 1'b0;
    for (int k = 0; k < H - 1; k++) begin
      check_boards({tag, "_tear"});
      chk({tag, "_busy_upd"}, 256'({ifa.busy, ifb.busy}), 256'(2'b11));
      case ($urandom_range(0, 3))
        1: ifa.step = 1'b1;
        2: ifa.clear = 1'b1;
        3: begin
          ifa.random_fill = 1'b1;
          ifa.seed        = $urandom;
        end
        default: ;
      endcase
      cyc();
      ifa.step        = 1'b0;
      ifa.clear       = 1'b0;
      ifa.random_fill = 1'b0;
    end
    ifa.frame_tick = 1'b1;
    cyc();
    ifa.frame_tick = 1'b0;
    chk({tag, "_busy_wait"}, 256'({ifa.busy, ifb.busy}), 256'(2'b11));
    chk({tag, "_gen_hold"}, 256'(ifa.gen_count), 256'(mgen));
    check_boards({tag, "_pre_commit"});
    ifa.frame_tick = 1'b1;
    cyc();
    ifa.frame_tick = 1'b0;
    model_gen();
    check_state(tag);
  endtask

  task automatic tick(output logic [1:0] b);
    ifa.frame_tick = 1'b1;
    cyc();
    ifa.frame_tick = 1'b0;
    b = {ifa.busy, ifb.busy};
    repeat (19) cyc();
  endtask

  initial begin
    logic [1:0] b;
    reset           = 1'b1;
    ifa.frame_tick  = 1'b0;
    ifa.run         = 1'b0;
    ifa.step        = 1'b0;
    ifa.random_fill = 1'b0;
    ifa.clear       = 1'b0;
    ifa.seed        = '0;
    ifa.rd_x        = '0;
    ifa.rd_y        = '0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    model_fill(32'd0, 1'b0);
    check_state("reset");

    do_fill("seed0", 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) do_step("step_default");

    do_fill("seed_rand", $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) do_step("step_rand");

    // Free-running: a generation starts on every third idle tick; run=0 holds the timer at zero.
    ifa.run = 1'b1;
    tick(b);
    tick(b);
    ifa.run = 1'b0;
    tick(b);
    tick(b);
    chk("run0_no_update", 256'(b), 256'(0));
    ifa.run = 1'b1;
    tick(b);
    chk("timer_1", 256'(b), 256'(0));
    tick(b);
    chk("timer_2", 256'(b), 256'(0));
    tick(b);
    chk("timer_expire", 256'(b), 256'(2'b11));
    tick(b);
    model_gen();
    check_state("run_commit0");
    for (int g = 0; g < 4; g++) begin
      tick(b);
      tick(b);
      tick(b);
      chk("run_expire", 256'(b), 256'(2'b11));
      tick(b);
      model_gen();
      check_state("run_commit");
    end
    ifa.step = 1'b1;
    cyc();
    ifa.step = 1'b0;
    chk("step_ignored_run", 256'({ifa.busy, ifb.busy}), 256'(0));
    ifa.run = 1'b0;
    cyc();

    do_fill("clear_and_rand", $urandom, 1'b1, 1'b1);
    do_step("dead_step");
    do_step("dead_step2");

    do_fill("pre_reset", $urandom, 1'b1, 1'b0);
    ifa.step = 1'b1;
    cyc();
    ifa.step = 1'b0;
    repeat (5) cyc();
    reset = 1'b1;
    #2;
    chk("reset_async_busy", 256'({ifa.busy, ifb.busy}), 256'(0));
    reset = 1'b0;
    cyc();
    model_fill(32'd0, 1'b0);
    check_state("reset_mid_update");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
